// File: rtl/ycbcr_block_tiler_if.sv
// ycbcr_block_tiler_if: raster pixel input stream and valid/ready 8x8 block output stream of the tiler
interface ycbcr_block_tiler_if #(
  parameter int IMG_WIDTH  = 320,
  parameter int DATA_WIDTH = 10
);
  localparam int BW = IMG_WIDTH / 8 > 1 ? $clog2(IMG_WIDTH / 8) : 1;
  logic                  valid_in, sof_in, ready_in;
  logic [DATA_WIDTH-1:0] y_in, cr_in, cb_in;
  logic                  valid_out, last_out, overflow_out;
  logic [DATA_WIDTH-1:0] y_out, cr_out, cb_out;
  logic [5:0]            idx_out;
  logic [BW-1:0]         blk_out;
  modport slave (
    input  valid_in, sof_in, y_in, cr_in, cb_in, ready_in,
    output valid_out, y_out, cr_out, cb_out, idx_out, blk_out, last_out, overflow_out
  );
  modport master (
    output valid_in, sof_in, y_in, cr_in, cb_in, ready_in,
    input  valid_out, y_out, cr_out, cb_out, idx_out, blk_out, last_out, overflow_out
  );
endinterface

// File: rtl/ycbcr_block_tiler.sv
// ycbcr_block_tiler: ping-pong 8-line strip buffer turning raster Y/Cr/Cb pixels into 8x8 blocks.
// Define LEVEL_SHIFT_EN to emit y_out as signed (y - 2^(DATA_WIDTH-1)).
module ycbcr_block_tiler #(
  parameter int IMG_WIDTH  = 320,
  parameter int DATA_WIDTH = 10
) (
  input logic clk_in,
  input logic rst_in,
  ycbcr_block_tiler_if.slave bus
);
  localparam int NB = IMG_WIDTH / 8;
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int AW = $clog2(16 * IMG_WIDTH);
  localparam int PW = 3 * DATA_WIDTH;
  localparam int EW = PW + BW + 6;
  typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;
  logic [PW-1:0] mem [16*IMG_WIDTH];
  logic [PW-1:0] rdata_q;
  logic [CW-1:0] wcol_q, wcol_d, col_w;
  logic [2:0] wrow_q, wrow_d, row_w;
  logic wbank_q, wbank_d, rbank_q, rbank_d, ovf_q, ovf_d;
  logic [1:0] full_q, full_d, cnt_q, cnt_d, pos;
  state_t state_q, state_d;
  logic [5:0] ridx_q, ridx_d, hidx;
  logic [BW-1:0] rblk_q, rblk_d, hblk;
  logic rdone_q, rdone_d, inflight_q, inflight_d;
  logic [BW+5:0] tag_q, tag_d;
  logic [EW-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [DATA_WIDTH-1:0] y_h;
  logic wr_en, rd_en, pop, free;
  logic [AW-1:0] waddr, raddr;
  assign hidx = e0_q[5:0];
  assign hblk = e0_q[BW+5:6];
  assign pop  = cnt_q != 2'd0 && bus.ready_in;
  assign free = pop && hidx == 6'd63 && hblk == BW'(NB - 1);
  // a bank freed this very cycle may take the pixel that would otherwise stall on it
  assign wr_en = bus.valid_in && (!full_q[wbank_q] || (free && rbank_q == wbank_q));
  assign row_w = bus.sof_in ? 3'd0 : wrow_q;
  assign col_w = bus.sof_in ? '0 : wcol_q;
  assign waddr = AW'(wbank_q) * AW'(8 * IMG_WIDTH) + AW'(row_w) * AW'(IMG_WIDTH) + AW'(col_w);
  assign raddr = AW'(rbank_q) * AW'(8 * IMG_WIDTH) + AW'(ridx_q[5:3]) * AW'(IMG_WIDTH)
               + AW'(rblk_q) * AW'(8) + AW'(ridx_q[2:0]);
  // reads are issued only when the 2-entry output buffer is guaranteed room for the returning word
  assign rd_en = state_q == PRIME || (state_q == STREAM && !rdone_q &&
                 ({1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, pop}) < 3'd2);
  always_comb begin
    wcol_d  = wcol_q;
    wrow_d  = wrow_q;
    wbank_d = wbank_q;
    full_d  = full_q;
    ovf_d   = ovf_q | (bus.valid_in && !wr_en);
    if (free) full_d[rbank_q] = 1'b0;
    if (wr_en) begin
      wcol_d = col_w == CW'(IMG_WIDTH - 1) ? '0 : col_w + 1'b1;
      wrow_d = col_w == CW'(IMG_WIDTH - 1) ? row_w + 3'd1 : row_w;
      if (col_w == CW'(IMG_WIDTH - 1) && row_w == 3'd7) begin
        wbank_d         = !wbank_q;
        full_d[wbank_q] = 1'b1;
      end
    end
  end
  always_comb begin
    state_d    = state_q;
    rbank_d    = rbank_q;
    ridx_d     = ridx_q;
    rblk_d     = rblk_q;
    rdone_d    = rdone_q;
    inflight_d = rd_en;
    tag_d      = rd_en ? {rblk_q, ridx_q} : tag_q;
    if (state_q == IDLE && full_q[rbank_q]) begin
      state_d = PRIME;
      ridx_d  = '0;
      rblk_d  = '0;
      rdone_d = 1'b0;
    end
    if (state_q == PRIME) state_d = STREAM;
    if (state_q == STREAM && free) begin
      state_d = IDLE;
      rbank_d = !rbank_q;
    end
    if (rd_en) begin
      ridx_d  = ridx_q + 6'd1;
      rblk_d  = ridx_q == 6'd63 ? rblk_q + 1'b1 : rblk_q;
      rdone_d = ridx_q == 6'd63 && rblk_q == BW'(NB - 1);
    end
  end
  always_comb begin
    cnt_d = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    pos   = cnt_q - {1'b0, pop};
    e0_d  = pop ? e1_q : e0_q;
    e1_d  = e1_q;
    if (inflight_q && pos == 2'd0) e0_d = {rdata_q, tag_q};
    if (inflight_q && pos != 2'd0) e1_d = {rdata_q, tag_q};
  end
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[waddr] <= {bus.y_in, bus.cr_in, bus.cb_in};
    if (rd_en) rdata_q <= mem[raddr];
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wcol_q     <= '0;
      wrow_q     <= '0;
      wbank_q    <= 1'b0;
      full_q     <= '0;
      ovf_q      <= 1'b0;
      state_q    <= IDLE;
      rbank_q    <= 1'b0;
      ridx_q     <= '0;
      rblk_q     <= '0;
      rdone_q    <= 1'b0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
      cnt_q      <= '0;
      e0_q       <= '0;
      e1_q       <= '0;
    end else begin
      wcol_q     <= wcol_d;
      wrow_q     <= wrow_d;
      wbank_q    <= wbank_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      rbank_q    <= rbank_d;
      ridx_q     <= ridx_d;
      rblk_q     <= rblk_d;
      rdone_q    <= rdone_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
      cnt_q      <= cnt_d;
      e0_q       <= e0_d;
      e1_q       <= e1_d;
    end
  end
  assign y_h = e0_q[EW-1 -: DATA_WIDTH];
`ifdef LEVEL_SHIFT_EN
  assign bus.y_out = {~y_h[DATA_WIDTH-1], y_h[DATA_WIDTH-2:0]};
`else
  assign bus.y_out = y_h;
`endif
  assign bus.cr_out       = e0_q[EW-1-DATA_WIDTH -: DATA_WIDTH];
  assign bus.cb_out       = e0_q[BW+6 +: DATA_WIDTH];
  assign bus.valid_out    = cnt_q != 2'd0;
  assign bus.idx_out      = hidx;
  assign bus.blk_out      = hblk;
  assign bus.last_out     = bus.valid_out && hidx == 6'd63;
  assign bus.overflow_out = ovf_q;
endmodule
